// File: rtl/ckt_sweep_pkg.sv
// ----------------------------------------------------------------------------
// ckt_sweep_pkg
// Shared types and helpers for the exhaustive-sweep controller.
//   sweep_state_t : controller FSM states (IDLE, APPLY, SAMPLE, DONE)
//   N_IN_DEFAULT  : default number of circuit inputs
//   vec_max_t     : widest vector the Gray helper handles
//   num_vec()     : size of the input vector space, 2**n
//   to_gray()     : binary-reflected Gray encoding of a step index
// ----------------------------------------------------------------------------
package ckt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int MAX_N_IN     = 16;

    typedef logic [MAX_N_IN-1:0] vec_max_t;

    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

    // Adjacent step indices map to vectors that differ in exactly one bit.
    function automatic vec_max_t to_gray(input vec_max_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/ckt_sweep_timer.sv
// ----------------------------------------------------------------------------
// ckt_sweep_timer
// Loadable down-counter used as the per-vector dwell timer. It stops at zero
// rather than wrapping, so the zero flag stays asserted until the next load.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (takes priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one while non-zero
//   o_zero     : count is zero
// ----------------------------------------------------------------------------
module ckt_sweep_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_count;

    // Count register: a load restarts the dwell, otherwise count down to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ckt_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ckt_sweep_ctrl
// Exhaustive sweep sequencer for a small N_IN-input combinational circuit.
// On start it walks every input vector, holds each for DWELL cycles, samples
// the circuit output for one further cycle, and builds the observed truth
// table, comparing it against EXPECTED as it goes.
//
// Configuration macro: SWEEP_GRAY_EN
//   defined   : vectors are applied in Gray order (one input toggles per step)
//   undefined : vectors are applied in binary order
// result, fail_vec and EXPECTED are always indexed by vector value.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_start      : begin a sweep (honoured only in IDLE or DONE)
//   i_abort      : cancel a sweep in progress
//   i_z_in       : output of the circuit under test
//   o_vec_out    : vector driven to the circuit (MSB = A2, LSB = C2)
//   o_busy       : sweep in progress (APPLY/SAMPLE)
//   o_done       : sweep complete, held until the next start
//   o_pass       : done with no mismatches
//   o_err_count  : number of mismatching vectors
//   o_fail_valid : at least one mismatch recorded
//   o_fail_vec   : first mismatching vector value
//   o_result     : captured truth table
// ----------------------------------------------------------------------------
module ckt_sweep_ctrl
    import ckt_sweep_pkg::*;
#(
    parameter int                  N_IN     = N_IN_DEFAULT,
    parameter int                  DWELL    = 4,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'hE8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_z_in,
    output logic [N_IN-1:0]      o_vec_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [N_IN:0]        o_err_count,
    output logic                 o_fail_valid,
    output logic [N_IN-1:0]      o_fail_vec,
    output logic [2**N_IN-1:0]   o_result
);

    localparam int                NUM_VEC  = num_vec(N_IN);
    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(NUM_VEC - 1);
    localparam logic [N_IN-1:0]   IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]     ERR_ONE  = (N_IN+1)'(1);

    sweep_state_t           r_state;
    sweep_state_t           w_next_state;

    logic [N_IN-1:0]        r_index;
    logic [N_IN-1:0]        r_vec_out;
    logic [N_IN:0]          r_err_count;
    logic                   r_fail_valid;
    logic [N_IN-1:0]        r_fail_vec;
    logic [NUM_VEC-1:0]     r_result;

    logic                   w_idle_like;
    logic                   w_running;
    logic                   w_go;
    logic                   w_abort_run;
    logic                   w_capture;
    logic                   w_last;
    logic                   w_advance;
    logic                   w_mismatch;
    logic                   w_timer_load;
    logic                   w_timer_en;
    logic                   w_timer_zero;
    logic [N_IN-1:0]        w_next_index;
    logic [N_IN-1:0]        w_next_vec;

    assign w_idle_like  = (r_state == IDLE) || (r_state == DONE);
    assign w_running    = (r_state == APPLY) || (r_state == SAMPLE);
    // Abort blocks a simultaneous start and suppresses a same-cycle capture.
    assign w_go         = w_idle_like && i_start && !i_abort;
    assign w_abort_run  = w_running && i_abort;
    assign w_capture    = (r_state == SAMPLE) && !i_abort;
    assign w_last       = (r_index == LAST_IDX);
    assign w_advance    = w_capture && !w_last;
    assign w_mismatch   = (i_z_in != EXPECTED[r_vec_out]);
    assign w_next_index = r_index + IDX_ONE;

`ifdef SWEEP_GRAY_EN
    assign w_next_vec   = N_IN'(to_gray(vec_max_t'(w_next_index)));
`else
    assign w_next_vec   = w_next_index;
`endif

    // Dwell restarts on every new vector; it only counts while in APPLY.
    assign w_timer_load = w_go || w_advance;
    assign w_timer_en   = (r_state == APPLY);

    ckt_sweep_timer #(
        .W          (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_timer_load),
        .i_load_val (DWELL_LD),
        .i_en       (w_timer_en),
        .o_zero     (w_timer_zero)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_go) begin
                    w_next_state = APPLY;
                end
            end
            APPLY: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else if (w_timer_zero) begin
                    w_next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = APPLY;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_pass = 1'b0;
        case (r_state)
            APPLY, SAMPLE: o_busy = 1'b1;
            DONE: begin
                o_done = 1'b1;
                o_pass = (r_err_count == '0);
            end
            default: ;
        endcase
    end

    // Sweep datapath. An abort only parks vec_out at zero; the partial
    // truth table and error record are left in place for debug.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_index      <= '0;
            r_vec_out    <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_result     <= '0;
        end else if (w_go) begin
            r_index      <= '0;
            r_vec_out    <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_result     <= '0;
        end else if (w_abort_run) begin
            r_vec_out    <= '0;
        end else if (w_capture) begin
            r_result[r_vec_out] <= i_z_in;
            if (w_mismatch) begin
                r_err_count <= r_err_count + ERR_ONE;
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_vec   <= r_vec_out;
                end
            end
            if (!w_last) begin
                r_index   <= w_next_index;
                r_vec_out <= w_next_vec;
            end
        end
    end

    assign o_vec_out    = r_vec_out;
    assign o_err_count  = r_err_count;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_vec   = r_fail_vec;
    assign o_result     = r_result;

endmodule

// File: doc/ckt_sweep_ctrl.md
Name: ckt_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a small N-input combinational circuit (e.g. the 3-input A2/B2/C2 -> Z circuit) in hardware.
- On start: walks every input vector, holds each for a programmable dwell time, and samples the circuit output.
- Builds the observed truth table and compares it against an expected table.
- Sits between a host/self-test controller and the circuit under test; vec_out drives the circuit inputs and z_in returns its output.

Parameters:
- N_IN, 3, number of circuit inputs; vector space is 2**N_IN.
- DWELL, 4, cycles each vector is held before sampling; legal range >= 1.
- EXPECTED, 8'hE8, expected truth table, width 2**N_IN; bit i is the expected Z for input value i (default is 3-input majority).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  cancel a sweep in progress.
- z_in  in  1  output of the circuit under test.
- vec_out  out  N_IN  input vector driven to the circuit; bit N_IN-1 is A2, bit 0 is C2.
- busy  out  1  high during APPLY/SAMPLE.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  done and err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors.
- fail_valid  out  1  at least one mismatch recorded.
- fail_vec  out  N_IN  first mismatching vector value.
- result  out  2**N_IN  captured truth table.

Behaviour:
- Reset (async, active-high): state=IDLE. vec_out, busy, done, pass, err_count, fail_valid, fail_vec and result are all 0. Reset mid-sweep clears everything immediately; no partial result is retained.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE, start=1, abort=0:
  - Next cycle -> APPLY with step index=0 and vec_out=first vector.
  - Dwell counter loaded with DWELL-1.
  - err_count, fail_valid, fail_vec, result cleared; done=0.
- APPLY: counter decrements each cycle; at 0 -> SAMPLE. vec_out is stable for the whole step.
- SAMPLE (one cycle, vec_out still held):
  - result[vec_out] <= z_in.
  - If z_in != EXPECTED[vec_out]: err_count++. If fail_valid==0, also set fail_vec=vec_out and fail_valid=1.
  - If index == 2**N_IN-1 -> DONE; otherwise index++, advance vec_out, reload counter, -> APPLY.
- DONE: done=1, busy=0; vec_out keeps the last vector; results held.
- Timing: each vector occupies DWELL+1 cycles. For the defaults, done rises 2**N_IN*(DWELL+1) = 40 cycles after the start edge.
- err_count cannot overflow because its width is N_IN+1.
- abort:
  - In APPLY/SAMPLE: next state IDLE, vec_out=0, busy=0, done=0; partial result/err_count kept for debug.
  - Abort has priority over start and over the SAMPLE capture in the same cycle.
  - In IDLE/DONE: no effect except blocking a simultaneous start.
- start while busy: ignored.
- start in DONE: restarts a full sweep.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined: vec_out = index ^ (index>>1), i.e. Gray order 000,001,011,010,110,111,101,100. Exactly one input toggles per step, for hazard-free stimulus. result, fail_vec and EXPECTED stay indexed by vector value, not by step.
- Undefined: vec_out = index (binary order). No Gray logic is synthesised.

Decomposition:
- Package ckt_sweep_pkg:
  - state enum (IDLE, APPLY, SAMPLE, DONE).
  - localparam helper NUM_VEC = 2**N_IN.
  - function to_gray for the vector encoding.
- Sub-module ckt_sweep_timer: loadable down-counter with load value, enable and zero flag. It implements the dwell count.

Test Plan:
1. Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE, busy=0.
2. Majority model on z_in, defaults, start pulse -> busy for 40 cycles, done=1, result=8'hE8, err_count=0, pass=1, fail_valid=0.
3. z_in tied 0 -> done after 40 cycles, result=8'h00, err_count=4, fail_valid=1, fail_vec=3'b011, pass=0.
4. abort at cycle 10 after start -> next cycle busy=0, vec_out=0, done=0. A new start then sweeps from vec 0 and completes normally.
5. start pulsed while busy -> ignored, completion still at 40 cycles. rst asserted while vec_out=3'b101 -> everything cleared, no done.
6. SWEEP_GRAY_EN defined with majority model -> vec_out sequence 000,001,011,010,110,111,101,100, each held 5 cycles; result=8'hE8, pass=1.
